// File: rtl/gtx_reset_arb_pkg.sv
// rtl/gtx_reset_arb_pkg.sv - shared types and constants for the GTX partial reset arbiter
//
// Package sata_phy_pkg:
//   arb_state_e  : arbiter FSM encoding (ST_IDLE, ST_ASSERT, ST_WAIT, ST_TOUT, ST_ACK), 3 bits
//   CH_TX/CH_RX  : channel ids latched into the arbiter's sel register
//   STAT_W       : width of the saturating statistics counters
//   sat_inc()    : saturating increment used by the statistics counters
package sata_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ASSERT = 3'd1,
        ST_WAIT   = 3'd2,
        ST_TOUT   = 3'd3,
        ST_ACK    = 3'd4
    } arb_state_e;

    localparam logic CH_TX = 1'b0;
    localparam logic CH_RX = 1'b1;

    localparam int STAT_W = 8;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/gtx_reset_arb_if.sv
// rtl/gtx_reset_arb_if.sv - request/ack, GTX reset pin and status bundle of the reset arbiter
//
// Signals:
//   txpcsreset_req / recal_tx_done : TX PCS reset request and its 1-cycle ack
//   rxreset_req / rxreset_ack      : RX reset request and its 1-cycle ack
//   gtx_txpcsreset / gtx_txresetdone : GTX TX PCS reset pin and its resetdone
//   gtx_rxreset / gtx_rxresetdone    : GTX RX reset pin and its resetdone
//   busy, reset_fail               : arbiter status
//   tx_rst_cnt, rx_rst_cnt, timeout_cnt : statistics counters
// Modports:
//   slave  : the arbiter
//   master : the environment (OOB controller + GTX wrapper)
interface gtx_reset_arb_if;

    logic                             txpcsreset_req;
    logic                             recal_tx_done;
    logic                             rxreset_req;
    logic                             rxreset_ack;
    logic                             gtx_txpcsreset;
    logic                             gtx_txresetdone;
    logic                             gtx_rxreset;
    logic                             gtx_rxresetdone;
    logic                             busy;
    logic                             reset_fail;
    logic [sata_phy_pkg::STAT_W-1:0]  tx_rst_cnt;
    logic [sata_phy_pkg::STAT_W-1:0]  rx_rst_cnt;
    logic [sata_phy_pkg::STAT_W-1:0]  timeout_cnt;

    modport slave (
        input  txpcsreset_req, rxreset_req, gtx_txresetdone, gtx_rxresetdone,
        output recal_tx_done, rxreset_ack, gtx_txpcsreset, gtx_rxreset,
        output busy, reset_fail, tx_rst_cnt, rx_rst_cnt, timeout_cnt
    );

    modport master (
        output txpcsreset_req, rxreset_req, gtx_txresetdone, gtx_rxresetdone,
        input  recal_tx_done, rxreset_ack, gtx_txpcsreset, gtx_rxreset,
        input  busy, reset_fail, tx_rst_cnt, rx_rst_cnt, timeout_cnt
    );

endinterface

// File: rtl/gtx_reset_arb_timer.sv
// rtl/gtx_reset_arb_timer.sv - loadable up/down counter with terminal flag (module rst_timer)
//
// Ports:
//   clk, rstn  : clock, synchronous active-low reset
//   load       : load load_val this cycle (wins over en)
//   load_val   : value to load
//   en         : count this cycle
//   up         : direction, 1 = increment, 0 = decrement
//   term_val   : value at which term is flagged
//   term       : cnt_q == term_val
module rst_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] term_val,
    output logic         term
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = up ? cnt_q + {{(W-1){1'b0}}, 1'b1} : cnt_q - {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term = (cnt_q == term_val);

endmodule

// File: rtl/gtx_reset_arb.sv
// rtl/gtx_reset_arb.sv - serializes TX PCS / RX partial GTX resets with timeout, retry and ack
//
// Ports:
//   clk  : usrclk2 (sata clk)
//   rstn : synchronous active-low reset
//   bus  : gtx_reset_arb_if.slave (requests/acks, GTX reset pins and resetdones, status, stats)
// Parameters:
//   PULSE_CYCLES   : cycles a GTX reset pin is held high (1..255)
//   TIMEOUT_CYCLES : cycles after release to wait for resetdone (16..65535)
//   MAX_RETRY      : re-issues after a timeout before acking with reset_fail (0..7)
// Build option:
//   GTX_RST_STATS_EN : when defined, tx_rst_cnt / rx_rst_cnt / timeout_cnt count saturating
//                      at 255; otherwise they are tied to 0 and no counter flops exist.
module gtx_reset_arb
    import sata_phy_pkg::*;
#(
    parameter int PULSE_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRY      = 2
) (
    input  logic            clk,
    input  logic            rstn,
    gtx_reset_arb_if.slave  bus
);

    localparam int         TW        = 16;
    localparam logic [TW-1:0] PULSE_LD  = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRY);

    arb_state_e state_q, state_d;
    logic       sel_q, sel_d;
    logic       pend_tx_q, pend_tx_d;
    logic       pend_rx_q, pend_rx_d;
    logic       txreq_prev_q, rxreq_prev_q;
    logic       seen_low_q, seen_low_d;
    logic [2:0] retry_q, retry_d;
    logic       fail_q, fail_d;
    logic       txpin_q, txpin_d;
    logic       rxpin_q, rxpin_d;
    logic       txack_q, txack_d;
    logic       rxack_q, rxack_d;
    logic       rfail_q, rfail_d;

    logic          tx_edge, rx_edge, sel_done;
    logic          tmr_load, tmr_en, tmr_up, tmr_term;
    logic [TW-1:0] tmr_load_val, tmr_term_val;

    assign tx_edge  = bus.txpcsreset_req & ~txreq_prev_q;
    assign rx_edge  = bus.rxreset_req & ~rxreq_prev_q;
    assign sel_done = (sel_q == CH_TX) ? bus.gtx_txresetdone : bus.gtx_rxresetdone;

    // One timer serves both phases: down-count of the pulse width in ASSERT,
    // up-count of the resetdone timeout in WAIT.
    rst_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .up       (tmr_up),
        .term_val (tmr_term_val),
        .term     (tmr_term)
    );

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        pend_tx_d    = pend_tx_q | tx_edge;
        pend_rx_d    = pend_rx_q | rx_edge;
        seen_low_d   = seen_low_q;
        retry_d      = retry_q;
        fail_d       = fail_q;
        tmr_load     = 1'b0;
        tmr_load_val = PULSE_LD;
        tmr_en       = 1'b0;
        tmr_up       = 1'b0;
        tmr_term_val = '0;

        case (state_q)
            ST_IDLE: begin
                if (pend_tx_q || pend_rx_q) begin
                    // A fresh edge arriving now re-arms the channel being cleared.
                    if (pend_tx_q) begin
                        sel_d     = CH_TX;
                        pend_tx_d = tx_edge;
                    end else begin
                        sel_d     = CH_RX;
                        pend_rx_d = rx_edge;
                    end
                    seen_low_d = 1'b0;
                    tmr_load   = 1'b1;
                    state_d    = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (!sel_done) begin
                    seen_low_d = 1'b1;
                end
                tmr_en = 1'b1;
                if (tmr_term) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = '0;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tmr_en       = 1'b1;
                tmr_up       = 1'b1;
                tmr_term_val = TOUT_LAST;
                if (!sel_done) begin
                    seen_low_d = 1'b1;
                end
                // Only a low->high transition counts: resetdone stuck high is a timeout.
                if (seen_low_q && sel_done) begin
                    state_d = ST_ACK;
                end else if (tmr_term) begin
                    state_d = ST_TOUT;
                end
            end
            ST_TOUT: begin
                if (retry_q < RETRY_MAX) begin
                    retry_d    = retry_q + 3'd1;
                    seen_low_d = 1'b0;
                    tmr_load   = 1'b1;
                    state_d    = ST_ASSERT;
                end else begin
                    fail_d  = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                retry_d = '0;
                fail_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pins follow the next state so they are high exactly while state_q is ASSERT.
        txpin_d = (state_d == ST_ASSERT) && (sel_d == CH_TX);
        rxpin_d = (state_d == ST_ASSERT) && (sel_d == CH_RX);
        txack_d = (state_q == ST_ACK) && (sel_q == CH_TX);
        rxack_d = (state_q == ST_ACK) && (sel_q == CH_RX);
        rfail_d = (state_q == ST_ACK) && fail_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            sel_q        <= CH_TX;
            pend_tx_q    <= 1'b0;
            pend_rx_q    <= 1'b0;
            txreq_prev_q <= 1'b0;
            rxreq_prev_q <= 1'b0;
            seen_low_q   <= 1'b0;
            retry_q      <= '0;
            fail_q       <= 1'b0;
            txpin_q      <= 1'b0;
            rxpin_q      <= 1'b0;
            txack_q      <= 1'b0;
            rxack_q      <= 1'b0;
            rfail_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            pend_tx_q    <= pend_tx_d;
            pend_rx_q    <= pend_rx_d;
            txreq_prev_q <= bus.txpcsreset_req;
            rxreq_prev_q <= bus.rxreset_req;
            seen_low_q   <= seen_low_d;
            retry_q      <= retry_d;
            fail_q       <= fail_d;
            txpin_q      <= txpin_d;
            rxpin_q      <= rxpin_d;
            txack_q      <= txack_d;
            rxack_q      <= rxack_d;
            rfail_q      <= rfail_d;
        end
    end

    assign bus.gtx_txpcsreset = txpin_q;
    assign bus.gtx_rxreset    = rxpin_q;
    assign bus.recal_tx_done  = txack_q;
    assign bus.rxreset_ack    = rxack_q;
    assign bus.reset_fail     = rfail_q;
    assign bus.busy           = (state_q != ST_IDLE);

`ifdef GTX_RST_STATS_EN
    logic [STAT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [STAT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [STAT_W-1:0] to_cnt_q, to_cnt_d;

    // Counts step in the ACK/TOUT state so they are current when the ack pulse is seen.
    always_comb begin
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        to_cnt_d = to_cnt_q;
        if (state_q == ST_ACK && sel_q == CH_TX) begin
            tx_cnt_d = sat_inc(tx_cnt_q);
        end
        if (state_q == ST_ACK && sel_q == CH_RX) begin
            rx_cnt_d = sat_inc(rx_cnt_q);
        end
        if (state_q == ST_TOUT) begin
            to_cnt_d = sat_inc(to_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            to_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    assign bus.tx_rst_cnt  = tx_cnt_q;
    assign bus.rx_rst_cnt  = rx_cnt_q;
    assign bus.timeout_cnt = to_cnt_q;
`else
    assign bus.tx_rst_cnt  = '0;
    assign bus.rx_rst_cnt  = '0;
    assign bus.timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_gtx_reset_arb.sv
// tb/tb_gtx_reset_arb.sv - directed self-checking bench for gtx_reset_arb
module tb_gtx_reset_arb;

`ifdef GTX_RST_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    gtx_reset_arb_if bus();

    gtx_reset_arb #(
        .PULSE_CYCLES   (8),
        .TIMEOUT_CYCLES (4096),
        .MAX_RETRY      (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- monitor (negedge, increments only) ----------------
    int cyc = 0;
    int tx_pulses = 0, rx_pulses = 0;
    int tx_run = 0, rx_run = 0, tx_last_run = 0, rx_last_run = 0;
    int tx_rise_cyc = 0, rx_rise_cyc = 0;
    int tx_acks = 0, rx_acks = 0, tx_ack_cyc = 0, rx_ack_cyc = 0;
    int ack_double = 0, both_high = 0, fails = 0, fail_alone = 0;
    logic tx_pin_p = 1'b0, rx_pin_p = 1'b0, tx_ack_p = 1'b0, rx_ack_p = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.gtx_txpcsreset && !tx_pin_p) begin
            tx_pulses = tx_pulses + 1; tx_rise_cyc = cyc; tx_run = 0;
        end
        if (bus.gtx_txpcsreset) tx_run = tx_run + 1;
        if (!bus.gtx_txpcsreset && tx_pin_p) tx_last_run = tx_run;
        if (bus.gtx_rxreset && !rx_pin_p) begin
            rx_pulses = rx_pulses + 1; rx_rise_cyc = cyc; rx_run = 0;
        end
        if (bus.gtx_rxreset) rx_run = rx_run + 1;
        if (!bus.gtx_rxreset && rx_pin_p) rx_last_run = rx_run;
        if (bus.gtx_txpcsreset && bus.gtx_rxreset) both_high = both_high + 1;
        if (bus.recal_tx_done) begin tx_acks = tx_acks + 1; tx_ack_cyc = cyc; end
        if (bus.rxreset_ack) begin rx_acks = rx_acks + 1; rx_ack_cyc = cyc; end
        if ((bus.recal_tx_done && tx_ack_p) || (bus.rxreset_ack && rx_ack_p)) ack_double = ack_double + 1;
        if (bus.reset_fail) begin
            fails = fails + 1;
            if (!(bus.recal_tx_done || bus.rxreset_ack)) fail_alone = fail_alone + 1;
        end
        tx_pin_p = bus.gtx_txpcsreset;
        rx_pin_p = bus.gtx_rxreset;
        tx_ack_p = bus.recal_tx_done;
        rx_ack_p = bus.rxreset_ack;
    end

    // ---------------- GTX resetdone model ----------------
    int tx_drop = 3, tx_rise = 20, rx_drop = 3, rx_rise = 20;
    bit tx_stuck = 1'b0, rx_stuck = 1'b0;
    int tx_hi = 0, tx_lo = 0, rx_hi = 0, rx_lo = 0;

    initial begin
        bus.gtx_txresetdone = 1'b1;
        bus.gtx_rxresetdone = 1'b1;
    end

    always @(negedge clk) begin
        if (bus.gtx_txpcsreset) begin
            tx_hi = tx_hi + 1; tx_lo = 0;
            if (!tx_stuck && tx_hi >= tx_drop) bus.gtx_txresetdone = 1'b0;
        end else begin
            tx_hi = 0;
            if (!bus.gtx_txresetdone) begin
                tx_lo = tx_lo + 1;
                if (tx_lo >= tx_rise) bus.gtx_txresetdone = 1'b1;
            end
        end
        if (bus.gtx_rxreset) begin
            rx_hi = rx_hi + 1; rx_lo = 0;
            if (!rx_stuck && rx_hi >= rx_drop) bus.gtx_rxresetdone = 1'b0;
        end else begin
            rx_hi = 0;
            if (!bus.gtx_rxresetdone) begin
                rx_lo = rx_lo + 1;
                if (rx_lo >= rx_rise) bus.gtx_rxresetdone = 1'b1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    int req_cyc = 0;

    task automatic pulse_req(input bit tx, input bit rx);
        if (tx) bus.txpcsreset_req = 1'b1;
        if (rx) bus.rxreset_req = 1'b1;
        req_cyc = cyc;
        tick(1);
        bus.txpcsreset_req = 1'b0;
        bus.rxreset_req = 1'b0;
    endtask

    task automatic wait_ack(input bit rx, input int budget, input string tag);
        int start;
        int n;
        start = rx ? rx_acks : tx_acks;
        n = 0;
        while (((rx ? rx_acks : tx_acks) == start) && n < budget) begin
            tick(1);
            n = n + 1;
        end
        check(tag, 32'((rx ? rx_acks : tx_acks) != start), 32'd1);
    endtask

    int s_txp, s_rxp, s_txa, s_rxa, s_fail, s_dbl, s_both, s_alone;

    task automatic snap();
        s_txp = tx_pulses; s_rxp = rx_pulses; s_txa = tx_acks; s_rxa = rx_acks;
        s_fail = fails; s_dbl = ack_double; s_both = both_high; s_alone = fail_alone;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.txpcsreset_req = 1'b0;
        bus.rxreset_req    = 1'b0;
        rstn = 1'b0;
        tick(3);
        rstn = 1'b1;
        tick(1);

        // reset state
        check("rst_txpin", 32'(bus.gtx_txpcsreset), 0);
        check("rst_rxpin", 32'(bus.gtx_rxreset), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_txack", 32'(bus.recal_tx_done), 0);
        check("rst_rxack", 32'(bus.rxreset_ack), 0);
        check("rst_fail", 32'(bus.reset_fail), 0);
        check("rst_txcnt", 32'(bus.tx_rst_cnt), 0);
        check("rst_rxcnt", 32'(bus.rx_rst_cnt), 0);
        check("rst_tocnt", 32'(bus.timeout_cnt), 0);

        // T1: single TX pulse request
        snap();
        pulse_req(1'b1, 1'b0);
        check("t1_busy", 32'(bus.busy), 0);
        tick(1);
        check("t1_busy_assert", 32'(bus.busy), 1);
        wait_ack(1'b0, 200, "t1_ack_seen");
        tick(3);
        check("t1_latency", 32'(tx_rise_cyc - req_cyc), 2);
        check("t1_width", 32'(tx_last_run), 8);
        check("t1_pulses", 32'(tx_pulses - s_txp), 1);
        check("t1_acks", 32'(tx_acks - s_txa), 1);
        check("t1_ack_single", 32'(ack_double - s_dbl), 0);
        check("t1_fail", 32'(fails - s_fail), 0);
        check("t1_txcnt", 32'(bus.tx_rst_cnt), STATS_ON ? 1 : 0);
        check("t1_busy_after", 32'(bus.busy), 0);

        // T2: TX and RX in the same cycle
        rx_drop = 2; rx_rise = 5;
        snap();
        pulse_req(1'b1, 1'b1);
        wait_ack(1'b1, 400, "t2_rxack_seen");
        tick(3);
        check("t2_txpulses", 32'(tx_pulses - s_txp), 1);
        check("t2_rxpulses", 32'(rx_pulses - s_rxp), 1);
        check("t2_txacks", 32'(tx_acks - s_txa), 1);
        check("t2_rxacks", 32'(rx_acks - s_rxa), 1);
        check("t2_both_high", 32'(both_high - s_both), 0);
        check("t2_tx_first", 32'(rx_rise_cyc > tx_ack_cyc), 1);
        check("t2_rx_last", 32'(rx_ack_cyc > tx_ack_cyc), 1);
        check("t2_rxwidth", 32'(rx_last_run), 8);
        check("t2_txcnt", 32'(bus.tx_rst_cnt), STATS_ON ? 2 : 0);
        check("t2_rxcnt", 32'(bus.rx_rst_cnt), STATS_ON ? 1 : 0);

        // T3: RX resetdone stuck high -> timeouts, retries, failed ack
        rx_stuck = 1'b1;
        snap();
        pulse_req(1'b0, 1'b1);
        wait_ack(1'b1, 20000, "t3_rxack_seen");
        tick(2);
        check("t3_rxpulses", 32'(rx_pulses - s_rxp), 3);
        check("t3_tocnt", 32'(bus.timeout_cnt), STATS_ON ? 3 : 0);
        check("t3_fails", 32'(fails - s_fail), 1);
        check("t3_fail_with_ack", 32'(fail_alone - s_alone), 0);
        check("t3_rxcnt", 32'(bus.rx_rst_cnt), STATS_ON ? 2 : 0);
        check("t3_busy_after", 32'(bus.busy), 0);
        rx_stuck = 1'b0;

        // T4: level request held 500 cycles, then re-raised
        snap();
        bus.txpcsreset_req = 1'b1;
        tick(500);
        check("t4_level_pulses", 32'(tx_pulses - s_txp), 1);
        check("t4_level_acks", 32'(tx_acks - s_txa), 1);
        bus.txpcsreset_req = 1'b0;
        tick(3);
        bus.txpcsreset_req = 1'b1;
        wait_ack(1'b0, 200, "t4_rearm_ack_seen");
        bus.txpcsreset_req = 1'b0;
        tick(3);
        check("t4_rearm_pulses", 32'(tx_pulses - s_txp), 2);
        check("t4_txcnt", 32'(bus.tx_rst_cnt), STATS_ON ? 4 : 0);

        // T5: rstn pulse while waiting for resetdone
        snap();
        pulse_req(1'b1, 1'b0);
        begin
            int n;
            n = 0;
            while (!(tx_pulses != s_txp && !bus.gtx_txpcsreset) && n < 100) begin
                tick(1);
                n = n + 1;
            end
            check("t5_reached_wait", 32'(tx_pulses != s_txp && !bus.gtx_txpcsreset), 1);
        end
        tick(3);
        check("t5_busy_in_wait", 32'(bus.busy), 1);
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        check("t5_pin_after_rst", 32'(bus.gtx_txpcsreset), 0);
        check("t5_busy_after_rst", 32'(bus.busy), 0);
        tick(60);
        check("t5_no_ack", 32'(tx_acks - s_txa), 0);
        check("t5_no_repulse", 32'(tx_pulses - s_txp), 1);
        check("t5_txcnt", 32'(bus.tx_rst_cnt), 0);
        check("t5_tocnt", 32'(bus.timeout_cnt), 0);

        // T6: 300 TX resets -> saturation (or zero without stats)
        tx_drop = 1; tx_rise = 2;
        snap();
        begin
            int misses;
            misses = 0;
            for (int i = 0; i < 300; i++) begin
                int start;
                int n;
                start = tx_acks;
                pulse_req(1'b1, 1'b0);
                n = 0;
                while (tx_acks == start && n < 100) begin
                    tick(1);
                    n = n + 1;
                end
                if (tx_acks == start) misses = misses + 1;
            end
            check("t6_missed_acks", 32'(misses), 0);
        end
        tick(2);
        check("t6_acks", 32'(tx_acks - s_txa), 300);
        check("t6_txcnt_sat", 32'(bus.tx_rst_cnt), STATS_ON ? 255 : 0);
        check("t6_rxcnt", 32'(bus.rx_rst_cnt), 0);
        check("t6_fails", 32'(fails - s_fail), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
